filt_run_ctrl: RTL and testbench

- Run-sequencer for the single-clock, non-stallable 18-bit FIR datapath (sine_filt class), which consumes one x_in every cycle.
- On a start command it primes the filter delay line with zeros, streams exactly num_samples upstream samples into the filter, then drains the pipeline.
- Sample outputs are tagged, so only results belonging to streamed samples are presented downstream, with a done pulse at the end of the run.
- Sits between the sample source (valid/ready) and the filter instance.

---
 rtl/filt_pkg.sv | 25 ++
 rtl/filt_tag_pipe.sv | 37 +++
 rtl/filt_run_ctrl.sv | 174 +++++++++++++++++
 tb/tb_filt_run_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// Shared types and constants for the FIR run sequencer: controller state
// encoding, default sample width and a small elaboration-time helper.
package filt_pkg;

   localparam int DEF_WIDTH = 18;

   typedef logic signed [DEF_WIDTH-1:0] sample_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRIME = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic int max_int(input int a, input int b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

endpackage

// File: rtl/filt_tag_pipe.sv
// Delay line that carries the "this filter input came from a real sample"
// tag alongside the filter datapath so it lines up with filt_y.
module filt_tag_pipe
#(
   parameter int DEPTH = 4
)
(
   input  logic clk,
   input  logic clr_n,
   input  logic tag_in,
   output logic tag_out
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   // next shift-register contents: new tag enters at bit 0
   always_comb begin
      sr_d    = sr_q;
      sr_d[0] = tag_in;
      for (int i = 1; i < DEPTH; i++) begin
         sr_d[i] = sr_q[i-1];
      end
   end

   // clr_n folds reset and abort, so in-flight tags die on either
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign tag_out = sr_q[DEPTH-1];

endmodule

// File: rtl/filt_run_ctrl.sv
// Run sequencer for a non-stallable FIR: primes the delay line with zeros,
// streams a fixed number of samples, drains, and forwards only tagged results.
module filt_run_ctrl
   import filt_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int FILT_LAT  = 4,
   parameter int PRIME_LEN = 32,
   parameter int CNT_W     = 16
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    abort,
   input  logic [CNT_W-1:0]        num_samples,
   input  logic signed [WIDTH-1:0] s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic signed [WIDTH-1:0] filt_x,
   input  logic signed [WIDTH-1:0] filt_y,
   output logic signed [WIDTH-1:0] m_data,
   output logic                    m_valid,
   output logic                    busy,
   output logic                    done,
   output logic                    underrun
);

   localparam int PH_MAX = max_int(PRIME_LEN, FILT_LAT + 1);
   localparam int PH_W   = $clog2(PH_MAX + 1);

   state_t                  state_q,    state_d;
   logic [CNT_W-1:0]        num_q,      num_d;
   logic [CNT_W-1:0]        run_cnt_q,  run_cnt_d;
   logic [PH_W-1:0]         ph_cnt_q,   ph_cnt_d;
   logic signed [WIDTH-1:0] filt_x_q,   filt_x_d;
   logic signed [WIDTH-1:0] m_data_q,   m_data_d;
   logic                    tag_q,      tag_d;
   logic                    m_valid_q,  m_valid_d;
   logic                    s_ready_q,  s_ready_d;
   logic                    busy_q,     busy_d;
   logic                    done_q,     done_d;
   logic                    underrun_q, underrun_d;

   logic                    tag_aligned_s;
   logic                    pipe_clr_n_s;

   assign pipe_clr_n_s = reset & ~abort;

   filt_tag_pipe #(
      .DEPTH   (FILT_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .clr_n   (pipe_clr_n_s),
      .tag_in  (tag_q),
      .tag_out (tag_aligned_s)
   );

   // next-state and next-output computation for the sequencer
   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      run_cnt_d  = run_cnt_q;
      ph_cnt_d   = ph_cnt_q;
      filt_x_d   = '0;
      tag_d      = 1'b0;
      underrun_d = underrun_q;
      done_d     = 1'b0;

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && (num_samples != '0)) begin
                  state_d    = ST_PRIME;
                  num_d      = num_samples;
                  underrun_d = 1'b0;
                  ph_cnt_d   = PH_W'(PRIME_LEN - 1);
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_PRIME: begin
               if (ph_cnt_q == '0) begin
                  state_d   = ST_RUN;
                  run_cnt_d = num_q - 1'b1;
               end else begin
                  ph_cnt_d = ph_cnt_q - 1'b1;
               end
            end
            ST_RUN: begin
               // the filter cannot stall: a missing sample becomes a tagged zero
               tag_d = 1'b1;
               if (s_valid) begin
                  filt_x_d = s_data;
               end else begin
                  underrun_d = 1'b1;
               end
               if (run_cnt_q == '0) begin
                  state_d  = ST_DRAIN;
                  ph_cnt_d = PH_W'(FILT_LAT);
               end else begin
                  run_cnt_d = run_cnt_q - 1'b1;
               end
            end
            ST_DRAIN: begin
               if (ph_cnt_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  ph_cnt_d = ph_cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      s_ready_d = (state_d == ST_RUN);
      if (abort) begin
         busy_d    = 1'b0;
         m_valid_d = 1'b0;
      end else begin
         busy_d    = (state_q != ST_IDLE);
         m_valid_d = tag_aligned_s;
      end
      m_data_d = filt_y;
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         num_q      <= '0;
         run_cnt_q  <= '0;
         ph_cnt_q   <= '0;
         filt_x_q   <= '0;
         m_data_q   <= '0;
         tag_q      <= 1'b0;
         m_valid_q  <= 1'b0;
         s_ready_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         run_cnt_q  <= run_cnt_d;
         ph_cnt_q   <= ph_cnt_d;
         filt_x_q   <= filt_x_d;
         m_data_q   <= m_data_d;
         tag_q      <= tag_d;
         m_valid_q  <= m_valid_d;
         s_ready_q  <= s_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   assign s_ready  = s_ready_q;
   assign filt_x   = filt_x_q;
   assign m_data   = m_data_q;
   assign m_valid  = m_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_filt_run_ctrl.sv
// Randomised scoreboard bench for filt_run_ctrl with a 4-cycle filter stub.
module tb_filt_run_ctrl;

   localparam int W  = 18;
   localparam int P  = 8;
   localparam int F  = 4;
   localparam int CW = 16;

   typedef struct {
      logic [W-1:0] data;
      int           ev;
   } exp_item_t;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [CW-1:0] num_samples = '0;
   logic [W-1:0]  s_data = '0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [W-1:0]  filt_x;
   logic [W-1:0]  filt_y = '0;
   logic [W-1:0]  m_data;
   logic          m_valid;
   logic          busy;
   logic          done;
   logic          underrun;

   logic [W-1:0]  d1 = '0, d2 = '0, d3 = '0;

   int            cyc = 0;
   int            n_checks = 0;
   int            n_fail = 0;
   bit            exp_underrun = 1'b0;
   exp_item_t     exp_q[$];
   int            done_q[$];
   exp_item_t     mon_it;
   int            mon_de;

   filt_run_ctrl #(
      .WIDTH(W), .FILT_LAT(F), .PRIME_LEN(P), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .num_samples(num_samples), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .filt_x(filt_x), .filt_y(filt_y),
      .m_data(m_data), .m_valid(m_valid), .busy(busy), .done(done),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // filter stub: filt_y after edge k+4 equals filt_x after edge k
   always @(posedge clk) begin
      d1     <= filt_x;
      d2     <= d1;
      d3     <= d2;
      filt_y <= d3;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // monitor: every result and done pulse must match the next expectation
   always @(negedge clk) begin
      if (m_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("m_valid_spurious", m_valid, 0);
         end else begin
            mon_it = exp_q.pop_front();
            chk("m_valid_edge", cyc, mon_it.ev);
            chk("m_data", m_data, mon_it.data);
         end
      end
      if (done === 1'b1) begin
         if (done_q.size() == 0) begin
            chk("done_spurious", done, 0);
         end else begin
            mon_de = done_q.pop_front();
            chk("done_edge", cyc, mon_de);
         end
      end
   end

   // drop expectations whose result would surface at or after edge ev
   task automatic flush_from(input int ev);
      exp_item_t keep[$];
      foreach (exp_q[k]) begin
         if (exp_q[k].ev < ev) keep.push_back(exp_q[k]);
      end
      exp_q = keep;
      done_q.delete();
   endtask

   task automatic do_run(input int n, input int drop_idx, input int abort_idx,
                         input bit start_mid, input int reset_t, input bit hold_start);
      int        e0, len, i;
      bit        stop;
      exp_item_t it;
      start       = 1'b1;
      num_samples = CW'(n);
      e0          = cyc + 1;
      @(posedge clk); #1;
      exp_underrun = 1'b0;
      done_q.push_back(e0 + P + n + F + 2);
      if (!hold_start) begin
         start       = 1'b0;
         num_samples = CW'($urandom);
      end
      len  = P + n + F + 2;
      stop = 1'b0;
      for (int t = 1; t <= len && !stop; t++) begin
         i = t - P - 1;
         chk("busy", busy, (t > 1));
         chk("s_ready", s_ready, (i >= 0 && i < n));
         chk("underrun", underrun, exp_underrun);
         if (i >= 0 && i < n) begin
            s_data = W'($urandom);
            if (i == abort_idx) begin
               abort   = 1'b1;
               s_valid = 1'($urandom);
            end else begin
               s_valid = (i != drop_idx);
               it.data = s_valid ? s_data : '0;
               it.ev   = cyc + 1 + F + 1;
               exp_q.push_back(it);
               if (!s_valid) exp_underrun = 1'b1;
            end
            if (start_mid && i == 1) begin
               start       = 1'b1;
               num_samples = CW'($urandom_range(1, 9));
            end
         end else begin
            s_valid = 1'($urandom);
            s_data  = W'($urandom);
         end
         if (t == reset_t) reset = 1'b0;
         @(posedge clk); #1;
         if (abort) begin
            flush_from(cyc);
            stop = 1'b1;
            chk("abort_filt_x", filt_x, 0);
            chk("abort_s_ready", s_ready, 0);
            chk("abort_m_valid", m_valid, 0);
            chk("abort_busy", busy, 0);
         end
         if (!reset) begin
            flush_from(cyc);
            stop         = 1'b1;
            exp_underrun = 1'b0;
            chk("rst_outs", {filt_x, m_data, m_valid, s_ready, done, underrun, busy}, 0);
         end
         abort = 1'b0;
         reset = 1'b1;
         if (!hold_start) start = 1'b0;
      end
   endtask

   task automatic idle_check();
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_s_ready", s_ready, 0);
      chk("idle_underrun", underrun, exp_underrun);
      chk("results_missing", exp_q.size(), 0);
      chk("done_missing", done_q.size(), 0);
   endtask

   initial begin
      int n, drop, ab;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {filt_x, m_data, m_valid, s_ready, done, underrun, busy}, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      do_run(5, -1, -1, 1'b0, -1, 1'b0);          // basic
      idle_check();
      do_run(4, 1, -1, 1'b0, -1, 1'b0);           // underrun on 2nd RUN cycle
      idle_check();
      start = 1'b1; num_samples = '0;             // N=0 ignored, underrun kept
      @(posedge clk); #1;
      start = 1'b0;
      idle_check();
      start = 1'b1; abort = 1'b1; num_samples = 16'd3;  // abort beats start
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      idle_check();
      do_run(6, -1, 2, 1'b0, -1, 1'b0);           // abort after 2 samples
      idle_check();
      do_run(4, -1, -1, 1'b1, -1, 1'b0);          // start during RUN ignored
      idle_check();
      do_run(4, -1, -1, 1'b0, P + 4 + 2, 1'b0);   // reset mid-drain
      idle_check();
      do_run(3, -1, -1, 1'b0, -1, 1'b0);
      idle_check();
      do_run(2, -1, -1, 1'b0, -1, 1'b1);          // back-to-back with start held
      do_run(2, -1, -1, 1'b0, -1, 1'b1);
      start = 1'b0;
      idle_check();

      for (int r = 0; r < 20; r++) begin
         n    = $urandom_range(1, 7);
         drop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
         ab   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
         do_run(n, drop, ab, 1'b0, -1, 1'b0);
         idle_check();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
